// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants for the MIPS core.
// Fetch entries pair an instruction word with its PC.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned INSTR_W      = 32;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Circular prefetch buffer: push, pop, flush, occupancy count.
// Head entry is read combinationally at the read pointer.
module ifetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (push && pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mips_ifetch.sv
// Instruction fetch stage: ROM issue, prefetch queue, redirects.
// Define IFETCH_BYPASS_EN to forward ROM data straight to the core.
module mips_ifetch
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  input  logic        if_ready,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CAP   = DEPTH[CW:0];
  localparam logic [31:0] RST_A = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   tag_q, tag_d;
  logic          pend_q, pend_d;
  logic          kill_q, kill_d;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic [31:0]   target;
  logic          issue, rsp_ok, bypass;
  logic          push, pop;
  fetch_entry_t  head, rsp;

  assign target = {redir_pc[31:2], 2'b00};
  assign rsp    = '{instr: imem_rdata, pc: tag_q};

  always_comb begin
    occ       = {1'b0, count} + {{CW{1'b0}}, pend_q};
    issue     = !reset && (redir_valid || (occ < CAP));
    rsp_ok    = pend_q && !kill_q && !redir_valid;
    imem_en   = issue;
    imem_addr = redir_valid ? target : fetch_pc_q;
`ifdef IFETCH_BYPASS_EN
    bypass    = rsp_ok && (count == '0);
`else
    bypass    = 1'b0;
`endif
    if_valid  = (count != '0) || bypass;
    if_instr  = bypass ? rsp.instr : head.instr;
    if_pc     = bypass ? rsp.pc : head.pc;
    if_pc4    = if_pc + PC_INC;
    pop       = if_valid && if_ready && !bypass;
    push      = rsp_ok && !(bypass && if_ready);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    pend_d     = issue;
    kill_d     = 1'b0;
    if (issue) begin
      fetch_pc_d = imem_addr + PC_INC;
      tag_d      = imem_addr;
    end
    // a redirect issues its own target, so only a suppressed
    // issue could leave an older response to drop next cycle
    if (redir_valid) begin
      kill_d = pend_q && !issue;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RST_A;
      tag_q      <= RST_A;
      pend_q     <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      pend_q     <= pend_d;
      kill_q     <= kill_d;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rsp),
    .pop       (pop),
    .flush     (redir_valid),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_mips_ifetch.sv
// Bench for mips_ifetch: queue-based reference model plus
// directed scenarios and randomized ready/redirect/reset traffic.
module tb_mips_ifetch;
  import mips_pkg::*;

  localparam int DEPTH = 4;
`ifdef IFETCH_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc4;
  logic        if_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = 32'h0;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] deliv [$];

  always #5 clk = ~clk;

  mips_ifetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .if_ready    (if_ready),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {2'b00, a[31:2]} ^ 32'h5EED_0000;
  endfunction

  always @(posedge clk)
    imem_rdata <= imem_en ? rom(imem_addr) : 32'hBAD0_BAD0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t",
                  name, got, exp, $time);
  endtask

  // reference model: queued PCs, one outstanding fetch, next PC
  logic [31:0] m_q [$];
  logic        m_inf = 1'b0;
  logic [31:0] m_inf_pc = 32'h0;
  logic [31:0] m_fpc = 32'h0;
  logic        e_en, e_v, e_byp, e_pop;
  logic [31:0] e_addr, e_pc;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_imem_en", 32'(imem_en), 0);
      m_q.delete();
      m_inf = 1'b0;
      m_fpc = 32'h0;
    end else begin
      e_en   = redir_valid || (m_q.size() + int'(m_inf) < DEPTH);
      e_addr = redir_valid ? {redir_pc[31:2], 2'b00} : m_fpc;
      e_byp  = BYP && m_q.size() == 0 && m_inf && !redir_valid;
      e_v    = m_q.size() > 0 || e_byp;
      e_pc   = m_q.size() > 0 ? m_q[0] : m_inf_pc;
      check("m_imem_en", 32'(imem_en), 32'(e_en));
      check("m_imem_addr", imem_addr, e_addr);
      check("m_if_valid", 32'(if_valid), 32'(e_v));
      if (e_v) begin
        check("m_if_pc", if_pc, e_pc);
        check("m_if_instr", if_instr, rom(e_pc));
        check("m_if_pc4", if_pc4, e_pc + 32'd4);
      end
      if (if_valid && if_ready) deliv.push_back(if_pc);
      e_pop = e_v && if_ready;
      if (e_pop && m_q.size() > 0) void'(m_q.pop_front());
      if (redir_valid) m_q.delete();
      else if (m_inf && !(e_pop && e_byp)) m_q.push_back(m_inf_pc);
      m_inf    = e_en;
      m_inf_pc = e_addr;
      if (e_en) m_fpc = e_addr + 32'd4;
    end
  end

  task automatic set_in(input logic rst, input logic rdy,
                        input logic rv, input logic [31:0] rpc);
    reset = rst;
    if_ready = rdy;
    redir_valid = rv;
    redir_pc = rpc;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic rdy);
    repeat (n) begin
      set_in(1'b0, rdy, 1'b0, 32'h0);
      step();
    end
  endtask

  initial begin
    int n0;
    logic bad;
    step();
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    step();

    // streaming from reset
    deliv.delete();
    for (int c = 0; c < 8; c++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      if (c == 0) begin
        check("t1_en0", 32'(imem_en), 1);
        check("t1_addr0", imem_addr, 32'h0);
      end
      if (c == 1) check("t1_addr1", imem_addr, 32'h4);
      if (c < LAT) check("t1_early_valid", 32'(if_valid), 0);
      if (c == LAT) begin
        check("t1_first_valid", 32'(if_valid), 1);
        check("t1_first_pc", if_pc, 32'h0);
        check("t1_first_instr", if_instr, 32'h5EED_0000);
        check("t1_first_pc4", if_pc4, 32'h4);
      end
      step();
    end
    check("t1_rate", 32'(deliv.size()), 32'(8 - LAT));
    for (int i = 0; i < 3; i++)
      check("t1_seq", deliv[i], 32'(4 * i));

    // stall until full, then drain
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    for (int c = 0; c < 10; c++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      if (c == 9) begin
        check("t2_full_en", 32'(imem_en), 0);
        check("t2_full_valid", 32'(if_valid), 1);
        check("t2_full_pc", if_pc, 32'h0);
      end
      step();
    end
    deliv.delete();
    for (int c = 0; c < 4; c++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      if (c == 0) check("t2_no_credit", 32'(imem_en), 0);
      step();
    end
    check("t2_drain_n", 32'(deliv.size()), 4);
    for (int i = 0; i < 4; i++)
      check("t2_drain", deliv[i], 32'(4 * i));

    // redirect with 3 queued and one pending
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    run(4, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, 32'h40);
    check("t3_en", 32'(imem_en), 1);
    check("t3_addr", imem_addr, 32'h40);
    step();
    deliv.delete();
    for (int k = 1; k <= 5; k++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      if (k < LAT) check("t3_gap", 32'(if_valid), 0);
      if (k == LAT) begin
        check("t3_lat_valid", 32'(if_valid), 1);
        check("t3_lat_pc", if_pc, 32'h40);
      end
      step();
    end
    check("t3_d0", deliv[0], 32'h40);
    check("t3_d1", deliv[1], 32'h44);

    // misaligned redirect with simultaneous pop
    set_in(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    check("t4_valid", 32'(if_valid), 1);
    check("t4_addr", imem_addr, 32'h100);
    n0 = deliv.size();
    step();
    check("t4_popped", 32'(deliv.size()), 32'(n0 + 1));
    run(5, 1'b1);
    check("t4_d0", deliv[n0 + 1], 32'h100);
    check("t4_d1", deliv[n0 + 2], 32'h104);

    // back-to-back redirects
    set_in(1'b0, 1'b1, 1'b1, 32'h20);
    step();
    n0 = deliv.size();
    set_in(1'b0, 1'b1, 1'b1, 32'h80);
    check("t5_addr", imem_addr, 32'h80);
    step();
    run(5, 1'b1);
    bad = 1'b0;
    for (int i = n0; i < deliv.size(); i++)
      if (deliv[i] == 32'h20) bad = 1'b1;
    check("t5_no_stale", 32'(bad), 0);
    check("t5_first", deliv[n0], 32'h80);

    // address wraparound
    set_in(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    step();
    n0 = deliv.size();
    run(6, 1'b1);
    check("t6_w0", deliv[n0], 32'hFFFF_FFF8);
    check("t6_w1", deliv[n0 + 1], 32'hFFFF_FFFC);
    check("t6_w2", deliv[n0 + 2], 32'h0);

    // reset with the queue out of credit
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    run(4, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    check("t7_rst_en", 32'(imem_en), 0);
    step();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    check("t7_valid", 32'(if_valid), 0);
    check("t7_addr", imem_addr, 32'h0);
    check("t7_en", 32'(imem_en), 1);
    n0 = deliv.size();
    step();
    run(6, 1'b1);
    check("t7_d0", deliv[n0], 32'h0);
    check("t7_d1", deliv[n0 + 1], 32'h4);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic rst, rdy, rv;
      logic [31:0] rpc;
      rst = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        rpc = $urandom;
      set_in(rst, rdy, rv, rpc);
      step();
    end
    run(4, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
